// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings and FSM state type for the memory stage.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

endpackage

// File: rtl/mem_stage_load_ext.sv
// load_ext: selects the addressed byte/halfword lane of a read word and extends it.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata_i[{addr_i, 3'b000} +: 8];
        h = rdata_i[{addr_i[1], 4'b0000} +: 16];
        data_o = funct3_i == F3_B  ? {{24{b[7]}}, b}  :
                 funct3_i == F3_H  ? {{16{h[15]}}, h} :
                 funct3_i == F3_BU ? {24'b0, b}       :
                 funct3_i == F3_HU ? {16'b0, h}       : rdata_i;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a blocking data-bus handshake, alignment
// checking, ack timeout and the M->W pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic        MemFaultW
);

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        kill_q;
    logic        is_load, is_mem, misal, tmo, done, bubble, wfault;
    logic [1:0]  sz;
    logic [31:0] ext;

    load_ext u_ext (
        .rdata_i (dmem_rdata),
        .addr_i  (ALUResultM[1:0]),
        .funct3_i(Funct3M),
        .data_o  (ext)
    );

    // kill_q marks the cycle after a timeout: the aborted op is still held on
    // the M inputs and must be dropped rather than reissued.
    always_comb begin
        sz = Funct3M[1:0];
        is_load = ResultSrcM == RS_LOAD;
        is_mem = is_load | MemWriteM;
        misal = (sz == F3_H[1:0] & ALUResultM[0]) | (sz == F3_W[1:0] & |ALUResultM[1:0]);
        dmem_req = ~reset & ~kill_q & is_mem & ~misal;
        dmem_we = dmem_req & MemWriteM;
        dmem_addr = {ALUResultM[31:2], 2'b00};
        dmem_be = (~MemWriteM | sz == F3_W[1:0]) ? 4'b1111 :
                  sz == F3_H[1:0] ? 4'b0011 << ALUResultM[1:0] : 4'b0001 << ALUResultM[1:0];
        dmem_wdata = sz == F3_W[1:0] ? WriteDataM :
                     sz == F3_H[1:0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
        StallM = dmem_req & ~dmem_ack;
        done = dmem_req & dmem_ack;
        tmo = (state_q == BUSY) & StallM & (cnt_q == TMO);
        wfault = (is_mem & misal & ~kill_q) | tmo;
        bubble = (StallM & ~tmo) | kill_q;
        state_d = (StallM & ~tmo) ? BUSY : IDLE;
        cnt_d = state_d == BUSY ? cnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            kill_q     <= 1'b0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            ResultSrcW <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            MemFaultW  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kill_q     <= tmo;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (done & is_load) ? ext : '0;
            PCPlus4W   <= PCPlus4M;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM & ~bubble & ~wfault;
            MemFaultW  <= wfault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table, reset sequences and randomized ops
// checked against a behavioural model of the memory stage.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk, reset;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM, dmem_ack;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic        dmem_req, dmem_we, StallM, RegWriteW, MemFaultW;
    logic [31:0] dmem_addr, dmem_wdata, ALUResultW, ReadDataW, PCPlus4W;
    logic [3:0]  dmem_be;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .StallM(StallM),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .ResultSrcW(ResultSrcW), .RdW(RdW), .RegWriteW(RegWriteW), .MemFaultW(MemFaultW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, wd, pc4, rdata;
        logic [4:0]  rd;
        logic        rw, mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        int          w;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rd;
        logic        e_rw, e_fault;
    } vec_t;

    int total = 0;
    int bad = 0;

    function automatic vec_t mk(logic [31:0] alu, wd, pc4, rdata, logic [4:0] rd,
                                logic rw, mw, logic [1:0] rs, logic [2:0] f3, int w,
                                logic e_req, logic [3:0] e_be, logic [31:0] e_wdata, e_rd,
                                logic e_rw, e_fault);
        vec_t v;
        v.alu = alu; v.wd = wd; v.pc4 = pc4; v.rdata = rdata; v.rd = rd;
        v.rw = rw; v.mw = mw; v.rs = rs; v.f3 = f3; v.w = w;
        v.e_req = e_req; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd = e_rd;
        v.e_rw = e_rw; v.e_fault = e_fault;
        return v;
    endfunction

    // Reference: derive the expected bus and writeback behaviour from access size,
    // offset and bus wait time with plain arithmetic.
    function automatic vec_t model(vec_t v);
        int sz, off;
        logic ld, mem, mis, tmo;
        longint x;
        ld = v.rs == 2'b01;
        mem = ld | v.mw;
        sz = v.f3[1:0] == 2'd0 ? 1 : v.f3[1:0] == 2'd1 ? 2 : 4;
        off = int'(v.alu % 4);
        mis = mem && (off % sz != 0);
        v.e_req = mem && !mis;
        tmo = v.e_req && v.w > TO;
        v.e_fault = mis || tmo;
        v.e_rw = v.e_fault ? 1'b0 : v.rw;
        v.e_be = v.mw ? 4'(((1 << sz) - 1) << off) : 4'hF;
        v.e_wdata = sz == 1 ? v.wd[7:0] * 32'h0101_0101 :
                    sz == 2 ? v.wd[15:0] * 32'h0001_0001 : v.wd;
        x = (longint'(v.rdata) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
        if (!v.f3[2] && sz < 4 && x >= (longint'(1) << (8 * sz - 1)))
            x -= longint'(1) << (8 * sz);
        v.e_rd = (ld && v.e_req && !tmo) ? 32'(x) : 32'd0;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic ack);
        ALUResultM = v.alu; WriteDataM = v.wd; PCPlus4M = v.pc4; dmem_rdata = v.rdata;
        RdM = v.rd; RegWriteM = v.rw; MemWriteM = v.mw; ResultSrcM = v.rs;
        Funct3M = v.f3; dmem_ack = ack;
    endtask

    task automatic check_bubble(input string n);
        chk({n, " bubble RegWriteW"}, RegWriteW, 0);
        chk({n, " bubble MemFaultW"}, MemFaultW, 0);
    endtask

    task automatic check_w_zero(input string n);
        chk({n, " ALUResultW"}, ALUResultW, 0);
        chk({n, " ReadDataW"}, ReadDataW, 0);
        chk({n, " PCPlus4W"}, PCPlus4W, 0);
        chk({n, " ResultSrcW"}, ResultSrcW, 0);
        chk({n, " RdW"}, RdW, 0);
        chk({n, " RegWriteW"}, RegWriteW, 0);
        chk({n, " MemFaultW"}, MemFaultW, 0);
    endtask

    // Upstream holds the op while a stall is expected; ack comes on cycle w.
    // A timed-out op stays on the inputs for one further cycle and is dropped.
    task automatic run_op(input vec_t v, input string n);
        int ncyc;
        ncyc = !v.e_req ? 1 : (v.e_fault ? TO + 1 : v.w + 1);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            drive(v, v.e_req ? (!v.e_fault && c == v.w) : 1'b1);
            #1;
            chk({n, " dmem_req"}, dmem_req, v.e_req);
            chk({n, " StallM"}, StallM, v.e_req && (v.e_fault || c < v.w));
            if (v.e_req) begin
                chk({n, " dmem_addr"}, dmem_addr, v.alu & ~32'd3);
                chk({n, " dmem_be"}, dmem_be, v.e_be);
                chk({n, " dmem_we"}, dmem_we, v.mw);
                if (v.mw) chk({n, " dmem_wdata"}, dmem_wdata, v.e_wdata);
            end
            @(posedge clk);
            #1;
            if (c < ncyc - 1) check_bubble(n);
            else if (v.e_fault) begin
                chk({n, " MemFaultW"}, MemFaultW, 1);
                chk({n, " RegWriteW"}, RegWriteW, 0);
            end else begin
                chk({n, " ALUResultW"}, ALUResultW, v.alu);
                chk({n, " ReadDataW"}, ReadDataW, v.e_rd);
                chk({n, " PCPlus4W"}, PCPlus4W, v.pc4);
                chk({n, " ResultSrcW"}, ResultSrcW, v.rs);
                chk({n, " RdW"}, RdW, v.rd);
                chk({n, " RegWriteW"}, RegWriteW, v.e_rw);
                chk({n, " MemFaultW"}, MemFaultW, 0);
            end
        end
        if (v.e_req && v.e_fault) begin
            @(negedge clk);
            drive(v, 1'b1);
            #1;
            chk({n, " post-timeout dmem_req"}, dmem_req, 0);
            chk({n, " post-timeout StallM"}, StallM, 0);
            @(posedge clk);
            #1;
            check_bubble({n, " post-timeout"});
        end
    endtask

    vec_t tbl[13];
    vec_t nop, lhu, lbu, v;
    logic [2:0] lf[5];

    initial begin
        tbl[0]  = mk(32'h1003, 32'h0, 32'h104, 32'h80AA_BBCC, 5'd1, 1, 0, 2'b01, 3'b000, 0,
                     1, 4'hF, 32'h0, 32'hFFFF_FF80, 1, 0);
        tbl[1]  = mk(32'h2002, 32'h0000_1234, 32'h108, 32'h0, 5'd0, 0, 1, 2'b00, 3'b001, 3,
                     1, 4'b1100, 32'h1234_1234, 32'h0, 0, 0);
        tbl[2]  = mk(32'h0006, 32'h0, 32'h10C, 32'hFFFF_FFFF, 5'd2, 1, 0, 2'b01, 3'b010, 0,
                     0, 4'hF, 32'h0, 32'h0, 0, 1);
        tbl[3]  = mk(32'h0010, 32'h0, 32'h110, 32'h5555_AAAA, 5'd3, 1, 0, 2'b01, 3'b101, 99,
                     1, 4'hF, 32'h0, 32'h0, 0, 1);
        tbl[4]  = mk(32'h1234_5678, 32'hAAAA, 32'h114, 32'h0, 5'd5, 1, 0, 2'b00, 3'b000, 0,
                     0, 4'hF, 32'h0, 32'h0, 1, 0);
        tbl[5]  = mk(32'h0100, 32'hDEAD_BEEF, 32'h118, 32'h0, 5'd0, 0, 1, 2'b00, 3'b010, 0,
                     1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0);
        tbl[6]  = mk(32'h0101, 32'h1234_56A5, 32'h11C, 32'h0, 5'd0, 0, 1, 2'b00, 3'b000, 1,
                     1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 0);
        tbl[7]  = mk(32'h0002, 32'h0, 32'h120, 32'h8001_7FFF, 5'd7, 1, 0, 2'b01, 3'b001, 2,
                     1, 4'hF, 32'h0, 32'hFFFF_8001, 1, 0);
        tbl[8]  = mk(32'h0002, 32'h0, 32'h124, 32'h00CC_0000, 5'd8, 1, 0, 2'b01, 3'b100, 0,
                     1, 4'hF, 32'h0, 32'h0000_00CC, 1, 0);
        tbl[9]  = mk(32'h0055, 32'h0, 32'h1234, 32'h0, 5'd1, 1, 0, 2'b10, 3'b000, 0,
                     0, 4'hF, 32'h0, 32'h0, 1, 0);
        tbl[10] = mk(32'h0008, 32'h0, 32'h128, 32'h1234_5678, 5'd9, 1, 0, 2'b01, 3'b010, 4,
                     1, 4'hF, 32'h0, 32'h1234_5678, 1, 0);
        tbl[11] = mk(32'h0003, 32'h0000_BEEF, 32'h12C, 32'h0, 5'd0, 0, 1, 2'b00, 3'b001, 0,
                     0, 4'hF, 32'h0, 32'h0, 0, 1);
        tbl[12] = mk(32'h0000, 32'h0, 32'h130, 32'h0000_007F, 5'd10, 1, 0, 2'b01, 3'b000, 0,
                     1, 4'hF, 32'h0, 32'h0000_007F, 1, 0);
        nop = mk(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 2'b00, 3'b000, 0, 0, 4'hF, 32'h0, 32'h0, 0, 0);
        lhu = mk(32'h0020, 32'h0, 32'h200, 32'h0, 5'd4, 1, 0, 2'b01, 3'b101, 99, 1, 4'hF, 32'h0, 32'h0, 0, 1);
        lbu = mk(32'h0001, 32'h0, 32'h204, 32'h0000_F000, 5'd11, 1, 0, 2'b01, 3'b100, 0,
                 1, 4'hF, 32'h0, 32'h0000_00F0, 1, 0);
        lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;

        reset = 1'b1;
        drive(tbl[5], 1'b0);
        #3;
        chk("reset dmem_req", dmem_req, 0);
        chk("reset dmem_we", dmem_we, 0);
        chk("reset StallM", StallM, 0);
        check_w_zero("reset");
        drive(nop, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 2);
            v.alu = $urandom; v.wd = $urandom; v.pc4 = $urandom; v.rdata = $urandom;
            v.rd = 5'($urandom); v.w = $urandom_range(0, 6);
            if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
            if (k == 0) begin
                v.rw = 1'($urandom); v.mw = 1'b0; v.f3 = 3'($urandom);
                v.rs = $urandom_range(0, 1) == 1 ? 2'b10 : 2'b00;
            end else if (k == 1) begin
                v.rw = 1'b1; v.mw = 1'b0; v.rs = 2'b01; v.f3 = lf[$urandom_range(0, 4)];
            end else begin
                v.rw = 1'b0; v.mw = 1'b1; v.rs = 2'b00; v.f3 = 3'($urandom_range(0, 2));
            end
            run_op(model(v), "rnd");
        end

        @(negedge clk);
        drive(lhu, 1'b0);
        #1;
        chk("midbusy issue dmem_req", dmem_req, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(lhu, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midbusy reset dmem_req", dmem_req, 0);
        chk("midbusy reset StallM", StallM, 0);
        check_w_zero("midbusy reset");
        drive(nop, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after reset RegWriteW", RegWriteW, 0);
        chk("after reset MemFaultW", MemFaultW, 0);
        run_op(lbu, "post-reset LBU");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, 15, maximum wait cycles in BUSY before a bus fault (range 1-255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ALUResultM  in  32  effective address, or ALU result passed through.
REQ-005 WriteDataM  in  32  store data, rs2.
REQ-006 PCPlus4M  in  32  return address passed through.
REQ-007 RdM  in  5  destination register.
REQ-008 RegWriteM, MemWriteM  in  1 each  register-write enable; store request.
REQ-009 ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4; 01 denotes a load.
REQ-010 Funct3M  in  3  access size and sign.
REQ-011 dmem_req, dmem_we  out  1 each  bus request; write strobe.
REQ-012 dmem_addr, dmem_wdata  out  32 each  word-aligned address (bits 1:0 = 0); lane-replicated store data.
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_ack  in  1  transfer complete; dmem_rdata in 32 is valid with ack.
REQ-015 StallM  out  1  freeze IF/ID/EX/MEM.
REQ-016 ALUResultW, ReadDataW, PCPlus4W  out  32 each  registered values to writeback.
REQ-017 ResultSrcW  out  2  registered result select.
REQ-018 RdW  out  5  registered destination register.
REQ-019 RegWriteW, MemFaultW  out  1 each  registered write enable; alignment or timeout fault.

Function
REQ-020 A memory op is a load (ResultSrcM=01) or a store (MemWriteM=1); other instructions pass to W in one cycle with ReadDataW=0.
REQ-021 Encodings: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-022 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; word 4'b1111; load requests use 1111.
REQ-023 Store data: SB replicates byte 4 times; SH replicates halfword twice; SW unchanged.
REQ-024 Misaligned (H with addr[0]=1, W with addr[1:0]!=0): no bus request; W gets MemFaultW=1, RegWriteW=0, one cycle.
REQ-025 FSM IDLE/BUSY: in IDLE an aligned op drives dmem_req=1 combinationally; ack in the same cycle completes with zero wait, otherwise next state is BUSY.
REQ-026 BUSY: req, we, addr, be and wdata held constant; wait counter increments each cycle; ack returns to IDLE.
REQ-027 Timeout: counter = ACK_TIMEOUT with no ack -> abort (req low next cycle), W gets MemFaultW=1, RegWriteW=0, return to IDLE.
REQ-028 StallM = dmem_req & ~dmem_ack (combinational); upstream holds M inputs stable while StallM=1.
REQ-029 While StallM=1, the W register loads a bubble: RegWriteW=0, MemFaultW=0, other fields don't-care.
REQ-030 On completion, W captures the M fields; ReadDataW = lane selected by addr[1:0], sign- or zero-extended per Funct3M.
REQ-031 dmem_ack while dmem_req=0 is ignored.
REQ-032 Latency: one cycle plus bus wait cycles; throughput one op per cycle under zero-wait ack.

Reset
REQ-033 Reset forces all W outputs to 0, FSM to IDLE, counter to 0; dmem_req, dmem_we and StallM are 0 while reset is high.
REQ-034 Reset asserted in BUSY abandons the transfer; no W write occurs for it.

Structure
REQ-035 Shared package holds: Funct3 load/store encodings, ResultSrc encodings, state enum {IDLE, BUSY}.
REQ-036 Sub-module load_ext (combinational lane select and extension) is instantiated once; everything else is inline.

Verification
REQ-037 LB, addr 0x1003, rdata 0x80AA_BBCC, zero-wait ack -> next cycle ReadDataW=0xFFFF_FF80, RegWriteW=1, StallM never high.
REQ-038 SH, addr 0x2002, WriteDataM 0x0000_1234, ack after 3 cycles -> be=1100, wdata=0x1234_1234, StallM high 3 cycles, W bubbles during stall.
REQ-039 LW, addr 0x0006 -> dmem_req stays 0, MemFaultW=1, RegWriteW=0 for one cycle.
REQ-040 LHU, ACK_TIMEOUT=4, no ack -> req drops after 4 BUSY cycles, MemFaultW=1, StallM=0 next cycle.
REQ-041 Reset pulse mid-BUSY -> req low immediately, all W outputs 0; next LBU at 0x0001, rdata 0x0000_F000 -> ReadDataW=0x0000_00F0.
REQ-042 ADD with RdM=5, then SW with zero-wait ack -> ALU result reaches W one cycle after issue, RegWriteW=1; the store reaches W with RegWriteW=0.
